// File: rtl/div_pkg.sv
// Shared types and constants for the non-restoring divider.
package div_pkg;

  // Controller sequence: IDLE -> LOAD -> ITER x WIDTH -> FIXUP -> DONE
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIter,
    StFixup,
    StDone
  } div_state_e;

  localparam int unsigned DefWidth = 32;

  // Quotient reported for a zero divisor; sliced to WIDTH by the user (WIDTH <= 64)
  localparam logic [63:0] DivZeroQ = '1;

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step on the {A,Q} pair.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   a_cur,
  input  logic [WIDTH-1:0] q_cur,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] a_sh;

  // Shift {A,Q} left by one; A's old MSB drops out, arithmetic stays modulo 2^(WIDTH+1)
  assign a_sh = {a_cur[WIDTH-1:0], q_cur[WIDTH-1]};

  // Subtract the divisor when A was non-negative, otherwise add it back in
  always_comb begin
    a_nxt = a_sh;
    if (!a_cur[WIDTH]) begin
      a_nxt = a_sh - {1'b0, m};
    end else begin
      a_nxt = a_sh + {1'b0, m};
    end
  end

  // New quotient bit is set when the updated A is non-negative
  assign q_nxt = {q_cur[WIDTH-2:0], ~a_nxt[WIDTH]};

endmodule

// File: rtl/div_controller.sv
// Sequential non-restoring divider controller: one quotient bit per clock.
// Optional macro DIV_CONTROLLER_SIGNED_EN adds two's-complement support via signed_op;
// without it signed_op is ignored and only unsigned division is built.
module div_controller
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] dvd_q, dvs_q;  // raw operands captured on an accepted start
  logic [WIDTH:0]   a_q;           // partial remainder, one extra sign bit
  logic [WIDTH-1:0] q_q, m_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             dz_q;

  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_res, rem_res, rem_fix;
  logic             accept, dvs_zero;

  assign accept   = start && ((state_q == StIdle) || (state_q == StDone));
  assign dvs_zero = (dvs_q == '0);

  // Restore a negative final remainder by adding the divisor back
  assign rem_fix = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];

`ifdef DIV_CONTROLLER_SIGNED_EN
  logic sgn_q, qneg_q, rneg_q;
  logic dvd_neg, dvs_neg;

  assign dvd_neg = sgn_q & dvd_q[WIDTH-1];
  assign dvs_neg = sgn_q & dvs_q[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dvd_q + 1'b1) : dvd_q;
  assign dvs_mag = dvs_neg ? (~dvs_q + 1'b1) : dvs_q;
  // Quotient sign follows the operand signs, remainder sign follows the dividend
  assign quo_res = qneg_q ? (~q_q + 1'b1) : q_q;
  assign rem_res = rneg_q ? (~rem_fix + 1'b1) : rem_fix;
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign dvd_mag = dvd_q;
  assign dvs_mag = dvs_q;
  assign quo_res = q_q;
  assign rem_res = rem_fix;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .a_cur (a_q),
    .q_cur (q_q),
    .m     (m_q),
    .a_nxt (a_nxt),
    .q_nxt (q_nxt)
  );

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = dvs_zero ? StDone : StIter;
      StIter:  if (cnt_q == LastStep) state_d = StFixup;
      StFixup: state_d = StDone;
      StDone:  state_d = start ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, magnitude load and per-cycle iteration
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
`ifdef DIV_CONTROLLER_SIGNED_EN
      sgn_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
`ifdef DIV_CONTROLLER_SIGNED_EN
        sgn_q <= signed_op;
`endif
      end
      case (state_q)
        StLoad: begin
          a_q    <= '0;
          q_q    <= dvd_mag;
          m_q    <= dvs_mag;
          cnt_q  <= '0;
`ifdef DIV_CONTROLLER_SIGNED_EN
          qneg_q <= dvd_neg ^ dvs_neg;
          rneg_q <= dvd_neg;
`endif
        end
        StIter: begin
          a_q <= a_nxt;
          q_q <= q_nxt;
          if (cnt_q != LastStep) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers change only on entry to DONE
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else if ((state_q == StLoad) && dvs_zero) begin
      quo_q <= DivZeroQ[WIDTH-1:0];
      rem_q <= dvd_q;
      dz_q  <= 1'b1;
    end else if (state_q == StFixup) begin
      quo_q <= quo_res;
      rem_q <= rem_res;
      dz_q  <= 1'b0;
    end
  end

  assign busy        = (state_q == StLoad) || (state_q == StIter) || (state_q == StFixup);
  assign done        = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_div_controller;

`ifdef DIV_CONTROLLER_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  div_controller #(
    .WIDTH (32)
  ) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_op   (signed_op),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV truncates toward zero like the divider
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      dz = 1'b1;
    end else if (SignedEn && s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      dz = 1'b0;
    end
  endfunction

  // Called at a negedge; the following posedge accepts the request
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // lat counts rising edges since (and including) the accepting edge
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
    logic [31:0] eq, er;
    logic edz;
    int lat;
    model(a, b, s, eq, er, edz);
    launch(a, b, s);
    wait_done(1, lat);
    check({tag, " latency"}, 32'(lat), edz ? 32'd2 : 32'd35);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb;
    logic rs;

    // Reset state
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clock);
    clear_n = 1'b1;

    // 100/7 accepted on the first edge after reset release
    launch(32'd100, 32'd7, 1'b0);
    check("100/7 busy", {31'd0, busy}, 32'd1);
    wait_done(1, lat);
    check("100/7 latency", 32'(lat), 32'd35);
    check("100/7 quotient", quotient, 32'd14);
    check("100/7 remainder", remainder, 32'd2);
    check("100/7 div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("100/7 done busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("done pulse width", {31'd0, done}, 32'd0);
    check("idle quotient hold", quotient, 32'd14);

    // Divide by zero short-circuits to DONE
    launch(32'h1234_5678, 32'd0, 1'b0);
    wait_done(1, lat);
    check("div0 latency", 32'(lat), 32'd2);
    check("div0 quotient", quotient, 32'hFFFF_FFFF);
    check("div0 remainder", remainder, 32'h1234_5678);
    check("div0 flag", {31'd0, div_by_zero}, 32'd1);
    @(negedge clock);

`ifdef DIV_CONTROLLER_SIGNED_EN
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(1, lat);
    check("-7/2 quotient", quotient, 32'hFFFF_FFFD);
    check("-7/2 remainder", remainder, 32'hFFFF_FFFF);
    @(negedge clock);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(1, lat);
    check("min/-1 quotient", quotient, 32'h8000_0000);
    check("min/-1 remainder", remainder, 32'd0);
    check("min/-1 flag", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock);
`else
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(1, lat);
    check("unsigned-only quotient", quotient, 32'h7FFF_FFFC);
    check("unsigned-only remainder", remainder, 32'd1);
    @(negedge clock);
`endif

    // Start during ITER cycle 5 must be ignored
    launch(32'd1000, 32'd7, 1'b0);
    repeat (5) @(negedge clock);
    check("iter5 busy", {31'd0, busy}, 32'd1);
    dividend = 32'd5;
    divisor = 32'd5;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(7, lat);
    check("ignored-start latency", 32'(lat), 32'd35);
    check("ignored-start quotient", quotient, 32'd142);
    check("ignored-start remainder", remainder, 32'd6);

    // Start while in DONE begins a new division immediately
    launch(32'd81, 32'd9, 1'b0);
    check("done-restart busy", {31'd0, busy}, 32'd1);
    wait_done(1, lat);
    check("done-restart latency", 32'(lat), 32'd35);
    check("done-restart quotient", quotient, 32'd9);
    check("done-restart remainder", remainder, 32'd0);
    @(negedge clock);

    // Asynchronous clear at ITER step 10
    launch(32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (10) @(negedge clock);
    check("pre-clear busy", {31'd0, busy}, 32'd1);
    #2 clear_n = 1'b0;
    #1;
    check("clear busy", {31'd0, busy}, 32'd0);
    check("clear done", {31'd0, done}, 32'd0);
    check("clear quotient", quotient, 32'd0);
    check("clear remainder", remainder, 32'd0);
    check("clear div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    launch(32'd9, 32'd3, 1'b0);
    wait_done(1, lat);
    check("post-clear latency", 32'(lat), 32'd35);
    check("post-clear quotient", quotient, 32'd3);
    check("post-clear remainder", remainder, 32'd0);
    @(negedge clock);

    // Boundary operands through the model
    run_model("min/-1 model", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    @(negedge clock);
    run_model("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(negedge clock);
    run_model("small/large", 32'd5, 32'hFFFF_FFFE, 1'b0);
    @(negedge clock);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_model($sformatf("rand%0d", i), ra, rb, rs);
      if ($urandom_range(0, 1) == 0) @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clear_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a division.
REQ-005 SHALL have ports dividend and divisor, input, WIDTH each, the operands, sampled only on an accepted start.
REQ-006 SHALL have port signed_op, input, 1, selecting two's-complement operands; it is sampled with start.
REQ-007 SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when results are valid.
REQ-009 SHALL have ports quotient and remainder, output, WIDTH each, holding the results.
REQ-010 SHALL have port div_by_zero, output, 1, a flag valid with done.

Function
REQ-011 SHALL implement the FSM states IDLE, LOAD, ITER, FIXUP and DONE.
REQ-012 SHALL accept start only when busy=0 (IDLE or DONE); start while busy SHALL be ignored with no state or output change.
REQ-013 Accepted start at edge k: LOAD during cycle k+1, ITER during k+2..k+WIDTH+1, FIXUP at k+WIDTH+2, DONE at k+WIDTH+3 (latency WIDTH+3 = 35 cycles).
REQ-014 LOAD SHALL latch operand magnitudes (absolute values when signed), clear the partial remainder A, and reset the iteration counter to 0.
REQ-015 ITER SHALL perform one non-restoring step per cycle: shift {A,Q} left; subtract the divisor if A>=0, else add it; Q[0]=~A[WIDTH]. A SHALL be WIDTH+1 bits wide.
REQ-016 The counter SHALL leave ITER after exactly WIDTH steps, with no wrap and no extra step.
REQ-017 FIXUP SHALL add the divisor back when A<0; when signed, it SHALL negate the quotient if the operand signs differ and negate the remainder if the dividend is negative.
REQ-018 A signed -2^(WIDTH-1) / -1 SHALL give quotient 0x80000000 and remainder 0, with no flag.
REQ-019 A divisor of 0 detected in LOAD SHALL go directly to DONE with quotient all ones, remainder = dividend and div_by_zero=1.
REQ-020 busy SHALL be 1 in LOAD, ITER and FIXUP and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-021 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-022 DONE SHALL go to LOAD if start=1, else to IDLE.

Reset
REQ-023 clear_n=0 SHALL immediately force IDLE, and set busy, done, div_by_zero, quotient, remainder, the counter and internal registers to 0, including mid-operation.
REQ-024 The first start SHALL be accepted on the first rising edge after clear_n deasserts.

Configuration
REQ-025 With DIV_CONTROLLER_SIGNED_EN defined, signed_op=1 SHALL select signed division per REQ-017/018.
REQ-026 Without DIV_CONTROLLER_SIGNED_EN, signed_op SHALL be ignored, all division SHALL be unsigned, and no sign logic SHALL be synthesized.

Structure
REQ-027 A shared package div_pkg SHALL hold the FSM state enum, the WIDTH default and the divide-by-zero quotient constant.
REQ-028 The single non-restoring iteration SHALL be a combinational sub-module div_step, instantiated once.

Verification
REQ-029 The bench SHALL check 100/7 unsigned: done exactly 35 cycles after start, quotient=14, remainder=2, div_by_zero=0.
REQ-030 The bench SHALL check 0x12345678/0: done after 2 cycles, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
REQ-031 The bench SHALL check, with the macro, signed -7/2: quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; and 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0.
REQ-032 The bench SHALL check that start with new operands at ITER cycle 5 is ignored and the first result is unchanged; start pulsed during DONE SHALL begin a new division.
REQ-033 The bench SHALL check that clear_n low at ITER step 10 gives busy=0 and all outputs 0 asynchronously, and that a following 9/3 yields quotient=3, remainder=0.
REQ-034 The bench SHALL check, without the macro, signed_op=1 with 0xFFFFFFF9/2: quotient=0x7FFFFFFC, remainder=1.
